// File: rtl/gfx256_pkg.sv
// Shared types and helpers for the gfx256 render-stage pixel writer.
package gfx256_pkg;

  localparam int MDW   = 256;
  localparam int LANES = MDW / 8;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    MERGE,
    HOLD,
    FLUSH,
    FLUSH_LOAD
  } pixel_writer_state_e;

  // Bytes occupied by one pixel; 0 marks an unsupported depth.
  function automatic logic [2:0] bytes_per_pixel(input logic [5:0] bpp);
    case (bpp)
      6'd8:    return 3'd1;
      6'd16:   return 3'd2;
      6'd32:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/gfx256_lane_merge.sv
// Folds one pixel (or a whole strip) into a 256-bit word and its byte enables.
module gfx256_lane_merge
  import gfx256_pkg::*;
(
  input  logic [MDW-1:0]   base_dat,
  input  logic [LANES-1:0] base_sel,
  input  logic [31:0]      color,
  input  logic [4:0]       lane,
  input  logic [2:0]       bpb,
  input  logic             strip,
  input  logic [MDW-1:0]   strip_color,
  output logic [MDW-1:0]   new_dat,
  output logic [LANES-1:0] new_sel
);

  logic [4:0] lane_idx;

  // Newer pixel bytes overwrite whatever already sits in their lanes.
  always_comb begin
    new_dat  = base_dat;
    new_sel  = base_sel;
    lane_idx = lane;
    if (strip) begin
      new_dat = strip_color;
      new_sel = '1;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (3'(b) < bpb) begin
          lane_idx                        = lane + 5'(b);
          new_dat[{lane_idx, 3'b000} +: 8] = color[8*b +: 8];
          new_sel[lane_idx]               = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gfx256_pixel_writer.sv
// Render-stage pixel writer: address calc, one-word write-combine buffer, word writes.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | buffer empty, waiting for a pixel
//   CALC       | register word address / lane for the presented pixel
//   MERGE      | fold pixel into buffer if same word, else go flush first
//   HOLD       | buffer valid, counting idle cycles toward auto-flush
//   FLUSH      | write buffer out, then return to IDLE
//   FLUSH_LOAD | write buffer out, then load the pending pixel
module gfx256_pixel_writer
  import gfx256_pkg::*;
#(
  parameter int point_width = 16,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [31:0]            target_base_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [5:0]             bpp_i,
  input  logic                   flush_i,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic [31:0]            pixel_color_i,
  input  logic                   strip_i,
  input  logic [MDW-1:0]         strip_color_i,
  input  logic                   write_i,
  output logic                   ack_o,
  output logic [31:0]            render_addr_o,
  output logic [MDW-1:0]         render_dat_o,
  output logic [LANES-1:0]       render_sel_o,
  output logic                   render_write_o,
  input  logic                   render_ack_i,
  output logic                   idle_o,
  output logic                   err_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  pixel_writer_state_e state_q, state_d;

  logic [2:0]       bpb_calc;
  logic [31:0]      off;
  logic             illegal;
  logic [31:0]      waddr_q;
  logic [4:0]       lane_q;
  logic [2:0]       bpb_q;
  logic [31:0]      buf_addr_q;
  logic [MDW-1:0]   buf_dat_q;
  logic [LANES-1:0] buf_sel_q;
  logic             buf_valid_q;
  logic             err_q;
  logic [CW-1:0]    idle_cnt_q;
  logic             hit;
  logic             accept;
  logic             timeout_hit;
  logic [MDW-1:0]   lm_base_dat;
  logic [LANES-1:0] lm_base_sel;
  logic [MDW-1:0]   lm_dat;
  logic [LANES-1:0] lm_sel;

  // Byte offset of the presented pixel; products wrap at 32 bits.
  always_comb begin
    bpb_calc = bytes_per_pixel(bpp_i);
    off      = (32'(pixel_y_i) * 32'(target_size_x_i) + 32'(pixel_x_i)) * 32'(bpb_calc);
  end

  assign illegal     = (bpb_calc == 3'd0);
  assign hit         = !buf_valid_q || (waddr_q == buf_addr_q);
  assign accept      = ((state_q == MERGE) && hit) || ((state_q == FLUSH_LOAD) && render_ack_i);
  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt_q == CW'(1));

  // A load after a flush starts from an empty word, not the outgoing one.
  assign lm_base_dat = (state_q == MERGE) ? buf_dat_q : '0;
  assign lm_base_sel = (state_q == MERGE) ? buf_sel_q : '0;

  gfx256_lane_merge u_lane_merge (
    .base_dat    (lm_base_dat),
    .base_sel    (lm_base_sel),
    .color       (pixel_color_i),
    .lane        (lane_q),
    .bpb         (bpb_q),
    .strip       (strip_i),
    .strip_color (strip_color_i),
    .new_dat     (lm_dat),
    .new_sel     (lm_sel)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; flush request outranks a new pixel while holding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (write_i) state_d = CALC;
      CALC:       state_d = illegal ? (buf_valid_q ? HOLD : IDLE) : MERGE;
      MERGE:      state_d = hit ? HOLD : FLUSH_LOAD;
      HOLD: begin
        if (flush_i)          state_d = FLUSH;
        else if (write_i)     state_d = CALC;
        else if (timeout_hit) state_d = FLUSH;
      end
      FLUSH:      if (render_ack_i) state_d = IDLE;
      FLUSH_LOAD: if (render_ack_i) state_d = HOLD;
      default:    state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    ack_o          = ((state_q == CALC) && illegal) || accept;
    render_write_o = (state_q == FLUSH) || (state_q == FLUSH_LOAD);
    idle_o         = (state_q == IDLE) && !buf_valid_q;
  end

  assign render_addr_o = render_write_o ? buf_addr_q : '0;
  assign render_dat_o  = render_write_o ? buf_dat_q  : '0;
  assign render_sel_o  = render_write_o ? buf_sel_q  : '0;
  assign err_o         = err_q;

  // Address calc, combine buffer and idle down-counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      waddr_q     <= '0;
      lane_q      <= '0;
      bpb_q       <= '0;
      buf_addr_q  <= '0;
      buf_dat_q   <= '0;
      buf_sel_q   <= '0;
      buf_valid_q <= 1'b0;
      err_q       <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      if (state_q == CALC) begin
        waddr_q <= target_base_i + {off[31:5], 5'b00000};
        lane_q  <= off[4:0];
        bpb_q   <= bpb_calc;
        if (illegal) err_q <= 1'b1;
      end
      if (accept) begin
        buf_addr_q  <= waddr_q;
        buf_dat_q   <= lm_dat;
        buf_sel_q   <= lm_sel;
        buf_valid_q <= 1'b1;
        idle_cnt_q  <= CW'(TIMEOUT);
      end else if ((state_q == FLUSH) && render_ack_i) begin
        buf_addr_q  <= '0;
        buf_dat_q   <= '0;
        buf_sel_q   <= '0;
        buf_valid_q <= 1'b0;
      end else if ((state_q == HOLD) && !flush_i && !write_i && (idle_cnt_q != '0)) begin
        idle_cnt_q <= idle_cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gfx256_pixel_writer.sv
// Randomised and directed bench for gfx256_pixel_writer against a byte-level model.
module tb_gfx256_pixel_writer;

  localparam int TMO = 16;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [31:0]  target_base_i = '0;
  logic [15:0]  target_size_x_i = '0;
  logic [5:0]   bpp_i = 6'd32;
  logic         flush_i = 1'b0;
  logic [15:0]  pixel_x_i = '0;
  logic [15:0]  pixel_y_i = '0;
  logic [31:0]  pixel_color_i = '0;
  logic         strip_i = 1'b0;
  logic [255:0] strip_color_i = '0;
  logic         write_i = 1'b0;
  logic         ack_o;
  logic [31:0]  render_addr_o;
  logic [255:0] render_dat_o;
  logic [31:0]  render_sel_o;
  logic         render_write_o;
  logic         render_ack_i = 1'b0;
  logic         idle_o;
  logic         err_o;

  always #5 clk_i = ~clk_i;

  gfx256_pixel_writer #(.point_width(16), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .target_base_i(target_base_i),
    .target_size_x_i(target_size_x_i), .bpp_i(bpp_i), .flush_i(flush_i),
    .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_color_i(pixel_color_i),
    .strip_i(strip_i), .strip_color_i(strip_color_i), .write_i(write_i),
    .ack_o(ack_o), .render_addr_o(render_addr_o), .render_dat_o(render_dat_o),
    .render_sel_o(render_sel_o), .render_write_o(render_write_o),
    .render_ack_i(render_ack_i), .idle_o(idle_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %0s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a 32-byte combine buffer plus a queue of expected word writes.
  typedef struct {
    logic [31:0]  addr;
    logic [255:0] dat;
    logic [31:0]  sel;
  } wr_t;

  wr_t          exp_q[$];
  logic [31:0]  m_addr = '0;
  logic [255:0] m_dat = '0;
  logic [31:0]  m_sel = '0;
  bit           m_valid = 0;

  task automatic model_flush();
    wr_t w;
    if (m_valid) begin
      w.addr = m_addr; w.dat = m_dat; w.sel = m_sel;
      exp_q.push_back(w);
    end
    m_valid = 0; m_dat = '0; m_sel = '0; m_addr = '0;
  endtask

  task automatic model_pixel(input logic [15:0] x, input logic [15:0] y, input logic [31:0] color,
                             input bit strip, input logic [255:0] scol, output bit same);
    int          bpb;
    logic [31:0] off, word;
    int          lane;
    bpb  = int'(bpp_i) / 8;
    off  = (32'(y) * 32'(target_size_x_i) + 32'(x)) * 32'(bpb);
    word = target_base_i + (off & 32'hFFFF_FFE0);
    lane = int'(off[4:0]);
    same = !m_valid || (word == m_addr);
    if (!same) model_flush();
    m_valid = 1;
    m_addr  = word;
    if (strip) begin
      m_dat = scol;
      m_sel = '1;
    end else begin
      for (int b = 0; b < bpb; b++) begin
        m_dat[8*(lane+b) +: 8] = color[8*b +: 8];
        m_sel[lane+b]          = 1'b1;
      end
    end
  endtask

  // Wishbone-side writer: random acceptance delay, compares every issued word.
  bit           hold_ack = 0;
  int           ack_delay = 0;
  int           wr_count = 0;
  logic [31:0]  last_addr = '0;
  logic [255:0] last_dat = '0;
  logic [31:0]  last_sel = '0;

  task automatic writer_compare();
    wr_t e;
    if (exp_q.size() == 0) begin
      check_eq("spurious_write", 256'(m_valid), 256'(1));
      model_flush();
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("wr_addr", 256'(render_addr_o), 256'(e.addr));
      check_eq("wr_sel", 256'(render_sel_o), 256'(e.sel));
      check_eq("wr_dat", render_dat_o, e.dat);
    end
    last_addr = render_addr_o;
    last_dat  = render_dat_o;
    last_sel  = render_sel_o;
    wr_count++;
  endtask

  initial begin
    forever begin
      @(posedge clk_i); #1;
      render_ack_i = 1'b0;
      if (rst_ni && render_write_o && !hold_ack) begin
        if (ack_delay > 0) ack_delay--;
        else begin
          writer_compare();
          render_ack_i = 1'b1;
          ack_delay    = $urandom_range(0, 3);
        end
      end
    end
  end

  // ack_o must never be high in two consecutive cycles.
  logic prev_ack = 1'b0;
  always @(negedge clk_i) begin
    if (ack_o) check_eq("ack_back2back", 256'(prev_ack), 256'(0));
    prev_ack = ack_o;
  end

  task automatic send_pixel(input logic [15:0] x, input logic [15:0] y, input logic [31:0] color,
                            input bit strip, input logic [255:0] scol);
    bit same;
    bit legal;
    int lat;
    same = 0;
    @(posedge clk_i); #1;
    legal = (bpp_i == 6'd8) || (bpp_i == 6'd16) || (bpp_i == 6'd32);
    if (legal) model_pixel(x, y, color, strip, scol, same);
    pixel_x_i = x; pixel_y_i = y; pixel_color_i = color;
    strip_i = strip; strip_color_i = scol; write_i = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk_i);
      if (ack_o) break;
      lat++;
      if (lat > 100) begin
        check_eq("ack_timeout", 256'(ack_o), 256'(1));
        break;
      end
    end
    if (legal && same)  check_eq("ack_lat_same", 256'(lat), 256'(2));
    else if (legal)     check_eq("ack_lat_change", 256'(lat >= 3), 256'(1));
    @(posedge clk_i); #1;
    write_i = 1'b0; strip_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (idle_o && !render_write_o) break;
    end
    check_eq("idle_reached", 256'(idle_o), 256'(1));
  endtask

  task automatic do_flush();
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    wait_idle();
    @(posedge clk_i); #1;
    flush_i = 1'b0;
  endtask

  task automatic set_cfg(input logic [31:0] base, input logic [15:0] sx, input logic [5:0] bpp);
    target_base_i = base; target_size_x_i = sx; bpp_i = bpp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           wc, n;
    logic [255:0] expv;
    logic [15:0]  rx, ry;

    // Reset values
    repeat (3) @(negedge clk_i);
    check_eq("rst_idle", 256'(idle_o), 256'(1));
    check_eq("rst_ack", 256'(ack_o), 256'(0));
    check_eq("rst_write", 256'(render_write_o), 256'(0));
    check_eq("rst_err", 256'(err_o), 256'(0));
    check_eq("rst_sel", 256'(render_sel_o), 256'(0));
    check_eq("rst_addr", 256'(render_addr_o), 256'(0));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // 32bpp, two adjacent pixels, auto-flush by timeout
    set_cfg(32'h1000, 16'd640, 6'd32);
    wc = wr_count;
    send_pixel(16'd0, 16'd0, 32'h1111_1111, 1'b0, '0);
    send_pixel(16'd1, 16'd0, 32'h2222_2222, 1'b0, '0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      n++;
      if (render_write_o) break;
    end
    check_eq("timeout_window", 256'((n >= TMO) && (n <= TMO + 3)), 256'(1));
    wait_idle();
    check_eq("t32_count", 256'(wr_count - wc), 256'(1));
    check_eq("t32_addr", 256'(last_addr), 256'(32'h1000));
    check_eq("t32_sel", 256'(last_sel), 256'(32'h0000_00FF));

    // 8bpp, fill one full word
    set_cfg(32'h2000, 16'd100, 6'd8);
    for (int i = 0; i < 32; i++)
      send_pixel(16'(i), 16'd0, {$urandom_range(0, 32'hFFFF), 8'h00, 8'(i)}, 1'b0, '0);
    do_flush();
    for (int i = 0; i < 32; i++) expv[8*i +: 8] = 8'(i);
    check_eq("t8_sel", 256'(last_sel), 256'(32'hFFFF_FFFF));
    check_eq("t8_dat", last_dat, expv);
    check_eq("t8_addr", 256'(last_addr), 256'(32'h2000));

    // 16bpp, word change flushes before the second ack
    set_cfg(32'h3000, 16'd640, 6'd16);
    send_pixel(16'd15, 16'd0, 32'h0000_BEEF, 1'b0, '0);
    wc = wr_count;
    send_pixel(16'd16, 16'd0, 32'h0000_CAFE, 1'b0, '0);
    check_eq("t16_flush_first", 256'(wr_count - wc), 256'(1));
    check_eq("t16_sel", 256'(last_sel), 256'(32'hC000_0000));
    check_eq("t16_addr", 256'(last_addr), 256'(32'h3000));
    do_flush();
    check_eq("t16_sel2", 256'(last_sel), 256'(32'h0000_0003));
    check_eq("t16_addr2", 256'(last_addr), 256'(32'h3020));

    // Strip over a buffered pixel in the same word
    set_cfg(32'h4000, 16'd640, 6'd32);
    send_pixel(16'd2, 16'd0, 32'h1234_5678, 1'b0, '0);
    send_pixel(16'd0, 16'd0, 32'h0, 1'b1, {32{8'hA5}});
    do_flush();
    check_eq("strip_dat", last_dat, {32{8'hA5}});
    check_eq("strip_sel", 256'(last_sel), 256'(32'hFFFF_FFFF));

    // Illegal depth, then flush request while idle
    set_cfg(32'h5000, 16'd640, 6'd12);
    wc = wr_count;
    send_pixel(16'd3, 16'd3, 32'hDEAD_BEEF, 1'b0, '0);
    check_eq("bad_bpp_err", 256'(err_o), 256'(1));
    repeat (20) @(negedge clk_i);
    check_eq("bad_bpp_nowrite", 256'(wr_count - wc), 256'(0));
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_eq("idle_flush_idle", 256'(idle_o), 256'(1));
      check_eq("idle_flush_nowr", 256'(render_write_o), 256'(0));
    end
    @(posedge clk_i); #1;
    flush_i = 1'b0;

    // Reset while a write is outstanding
    set_cfg(32'h5000, 16'd640, 6'd32);
    hold_ack = 1;
    send_pixel(16'd0, 16'd0, 32'h5555_AAAA, 1'b0, '0);
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (render_write_o) break;
    end
    check_eq("rw_pending", 256'(render_write_o), 256'(1));
    rst_ni = 1'b0;
    #1;
    check_eq("rw_rst_write", 256'(render_write_o), 256'(0));
    check_eq("rw_rst_idle", 256'(idle_o), 256'(1));
    check_eq("rw_rst_sel", 256'(render_sel_o), 256'(0));
    check_eq("rw_rst_dat", render_dat_o, 256'(0));
    check_eq("rw_rst_err", 256'(err_o), 256'(0));
    flush_i = 1'b0;
    exp_q.delete();
    m_valid = 0; m_dat = '0; m_sel = '0; m_addr = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni   = 1'b1;
    hold_ack = 0;
    repeat (5) @(negedge clk_i);
    check_eq("rw_after_write", 256'(render_write_o), 256'(0));
    check_eq("rw_after_idle", 256'(idle_o), 256'(1));

    // Randomised traffic
    for (int batch = 0; batch < 6; batch++) begin
      case ($urandom_range(0, 2))
        0:       bpp_i = 6'd8;
        1:       bpp_i = 6'd16;
        default: bpp_i = 6'd32;
      endcase
      target_base_i   = {$urandom_range(0, 32'h07FF_FFFF), 5'b00000};
      target_size_x_i = 16'($urandom_range(8, 200));
      rx = 16'($urandom_range(0, 63));
      ry = 16'($urandom_range(0, 3));
      for (int p = 0; p < 30; p++) begin
        rx = rx + 16'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) ry = 16'($urandom_range(0, 3));
        send_pixel(rx, ry, $urandom, ($urandom_range(0, 7) == 0),
                   {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        if ($urandom_range(0, 9) == 0) do_flush();
        else repeat ($urandom_range(0, 3)) @(posedge clk_i);
      end
      if (batch % 2 == 0) do_flush();
      else wait_idle();
    end

    check_eq("end_queue_empty", 256'(exp_q.size()), 256'(0));
    check_eq("end_model_empty", 256'(m_valid), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
